// File: rtl/rs_logic_pkg.sv
// rs_logic_pkg
// Shared types and constants for the logic-unit reservation station:
// operand/tag/ROB widths, the CDB broadcast record (cdb_t), the station
// entry record (rs_entry_t) and a CDB tag-match helper.
package rs_logic_pkg;

  localparam int WIDTH_OP     = 3;
  localparam int WORD_SIZE_P  = 16;
  localparam int ROB_ENTRY    = 16;
  localparam int NUM_PHYS_REG = 32;
  localparam int FLAGS_W      = 4;
  localparam int TAG_W        = $clog2(NUM_PHYS_REG);
  localparam int ROB_W        = $clog2(ROB_ENTRY);

  // Logic-unit operations; the station carries them opaquely.
  typedef enum logic [WIDTH_OP-1:0] {
    OP_AND  = 3'd0,
    OP_XOR  = 3'd1,
    OP_OR   = 3'd2,
    OP_NEG  = 3'd3,
    OP_LSLS = 3'd4,
    OP_LSRS = 3'd5,
    OP_ASRS = 3'd6,
    OP_RORS = 3'd7
  } logic_op_e;

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       dest;
    logic [FLAGS_W-1:0]     flags;
    logic [WORD_SIZE_P-1:0] result;
  } cdb_t;

  localparam int CDB_WIDTH = $bits(cdb_t);

  typedef struct packed {
    logic                   rdy;
    logic [TAG_W-1:0]       tag;
    logic [WORD_SIZE_P-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic                valid;
    logic [WIDTH_OP-1:0] opcode;
    rs_src_t             src1;
    rs_src_t             src2;
    logic [ROB_W-1:0]    rob_dest;
    logic [TAG_W-1:0]    reg_dest;
  } rs_entry_t;

  localparam int RS_ENTRY_WIDTH = $bits(rs_entry_t);

  // True when a waiting operand with this tag is satisfied by the broadcast.
  function automatic logic tag_hit(input cdb_t cdb, input logic rdy,
                                   input logic [TAG_W-1:0] tag);
    return cdb.valid && !rdy && (tag == cdb.dest);
  endfunction

endpackage

// File: rtl/rs_logic_age_matrix.sv
// rs_age_matrix
// Exact age tracking for RS_ENTRY station slots. Row i bit j = 1 means
// entry i is older than entry j. A newly allocated entry becomes the
// youngest: its row is cleared and its column is set in every other row.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   flush_i         clear all age state
//   alloc_i         one-hot slot being written this cycle
//   dealloc_i       one-hot slot being issued this cycle
//   req_i           slots eligible for selection
//   grant_o         one-hot oldest requesting slot (combinational)
module rs_age_matrix
  import rs_logic_pkg::*;
#(
  parameter int RS_ENTRY = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                flush_i,
  input  logic [RS_ENTRY-1:0] alloc_i,
  input  logic [RS_ENTRY-1:0] dealloc_i,
  input  logic [RS_ENTRY-1:0] req_i,
  output logic [RS_ENTRY-1:0] grant_o
);

  logic [RS_ENTRY-1:0] age_q [RS_ENTRY];
  logic [RS_ENTRY-1:0] age_d [RS_ENTRY];

  // Next age state: alloc makes the slot youngest, dealloc drops its row.
  always_comb begin
    for (int i = 0; i < RS_ENTRY; i++) begin
      for (int j = 0; j < RS_ENTRY; j++) begin
        if (flush_i || alloc_i[i] || (i == j)) begin
          age_d[i][j] = 1'b0;
        end else if (alloc_i[j]) begin
          age_d[i][j] = 1'b1;
        end else if (dealloc_i[i]) begin
          age_d[i][j] = 1'b0;
        end else begin
          age_d[i][j] = age_q[i][j];
        end
      end
    end
  end

  // Grant a requester only if no other requester is older than it.
  always_comb begin
    logic blocked;
    for (int i = 0; i < RS_ENTRY; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_ENTRY; j++) begin
        blocked = blocked | (req_i[j] & age_q[j][i]);
      end
      grant_o[i] = req_i[i] & ~blocked;
    end
  end

  // Age state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < RS_ENTRY; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_ENTRY; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: rtl/rs_logic.sv
// rs_logic
// Reservation station for the logic functional unit. Buffers dispatched
// ops until both operands are ready, snoops the CDB for wake-up, and
// issues the oldest ready op (one per cycle) on registered FU inputs.
// Optional feature macro: RS_WAKEUP_BYPASS_EN -- an entry woken by the
// CDB in cycle t may be selected in cycle t with the CDB value muxed in.
// Ports:
//   clk_i, reset_i, flush_i     clock, sync active-high reset, squash
//   disp_*_i / disp_ready_o     dispatch handshake and op payload
//   cdb_i                       result broadcast (cdb_t)
//   exe_v_o, opcode_o, operand1_o, operand2_o, rob_dest_o, reg_dest_o
//                               registered issue to the logic FU
module rs_logic
  import rs_logic_pkg::*;
#(
  parameter int RS_ENTRY = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   disp_v_i,
  output logic                   disp_ready_o,
  input  logic [WIDTH_OP-1:0]    disp_opcode_i,
  input  logic                   disp_src1_rdy_i,
  input  logic                   disp_src2_rdy_i,
  input  logic [TAG_W-1:0]       disp_src1_tag_i,
  input  logic [TAG_W-1:0]       disp_src2_tag_i,
  input  logic [WORD_SIZE_P-1:0] disp_src1_val_i,
  input  logic [WORD_SIZE_P-1:0] disp_src2_val_i,
  input  logic [ROB_W-1:0]       disp_rob_dest_i,
  input  logic [TAG_W-1:0]       disp_reg_dest_i,
  input  logic [CDB_WIDTH-1:0]   cdb_i,
  output logic                   exe_v_o,
  output logic [WIDTH_OP-1:0]    opcode_o,
  output logic [WORD_SIZE_P-1:0] operand1_o,
  output logic [WORD_SIZE_P-1:0] operand2_o,
  output logic [ROB_W-1:0]       rob_dest_o,
  output logic [TAG_W-1:0]       reg_dest_o
);

  cdb_t                cdb_s;
  rs_entry_t           ent_q   [RS_ENTRY];
  rs_entry_t           ent_d   [RS_ENTRY];
  rs_entry_t           woken_s [RS_ENTRY];
  rs_entry_t           new_s;
  rs_entry_t           sel_s;
  logic [RS_ENTRY-1:0] req_s;
  logic [RS_ENTRY-1:0] grant_s;
  logic [RS_ENTRY-1:0] alloc_s;
  logic [RS_ENTRY-1:0] alloc_fire_s;
  logic                disp_fire_s;
  logic                exe_v_d;
  logic                disp_ready_d;

  logic                   disp_ready_q;
  logic                   exe_v_q;
  logic [WIDTH_OP-1:0]    opcode_q;
  logic [WORD_SIZE_P-1:0] operand1_q;
  logic [WORD_SIZE_P-1:0] operand2_q;
  logic [ROB_W-1:0]       rob_dest_q;
  logic [TAG_W-1:0]       reg_dest_q;

  // Fields the station carries but never consumes after selection.
  logic unused_s;
  assign unused_s = ^{cdb_s.flags, sel_s.valid, sel_s.src1.rdy, sel_s.src1.tag,
                      sel_s.src2.rdy, sel_s.src2.tag};

  assign cdb_s       = cdb_t'(cdb_i);
  assign disp_fire_s = disp_v_i & disp_ready_q;

  // CDB wake-up view of every entry and the select request vector.
  always_comb begin
    for (int i = 0; i < RS_ENTRY; i++) begin
      woken_s[i] = ent_q[i];
      if (ent_q[i].valid && tag_hit(cdb_s, ent_q[i].src1.rdy, ent_q[i].src1.tag)) begin
        woken_s[i].src1.rdy = 1'b1;
        woken_s[i].src1.val = cdb_s.result;
      end else begin
        woken_s[i].src1 = ent_q[i].src1;
      end
      if (ent_q[i].valid && tag_hit(cdb_s, ent_q[i].src2.rdy, ent_q[i].src2.tag)) begin
        woken_s[i].src2.rdy = 1'b1;
        woken_s[i].src2.val = cdb_s.result;
      end else begin
        woken_s[i].src2 = ent_q[i].src2;
      end
`ifdef RS_WAKEUP_BYPASS_EN
      req_s[i] = woken_s[i].valid & woken_s[i].src1.rdy & woken_s[i].src2.rdy;
`else
      req_s[i] = ent_q[i].valid & ent_q[i].src1.rdy & ent_q[i].src2.rdy;
`endif
    end
  end

  // Lowest-index free slot, one-hot.
  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < RS_ENTRY; i++) begin
      alloc_s[i] = ~ent_q[i].valid & ~seen;
      seen       = seen | ~ent_q[i].valid;
    end
  end

  assign alloc_fire_s = disp_fire_s ? alloc_s : {RS_ENTRY{1'b0}};

  // Incoming entry, with same-cycle CDB capture of waiting sources.
  always_comb begin
    new_s          = '0;
    new_s.valid    = 1'b1;
    new_s.opcode   = disp_opcode_i;
    new_s.rob_dest = disp_rob_dest_i;
    new_s.reg_dest = disp_reg_dest_i;
    new_s.src1.tag = disp_src1_tag_i;
    new_s.src2.tag = disp_src2_tag_i;
    if (tag_hit(cdb_s, disp_src1_rdy_i, disp_src1_tag_i)) begin
      new_s.src1.rdy = 1'b1;
      new_s.src1.val = cdb_s.result;
    end else begin
      new_s.src1.rdy = disp_src1_rdy_i;
      new_s.src1.val = disp_src1_val_i;
    end
    if (tag_hit(cdb_s, disp_src2_rdy_i, disp_src2_tag_i)) begin
      new_s.src2.rdy = 1'b1;
      new_s.src2.val = cdb_s.result;
    end else begin
      new_s.src2.rdy = disp_src2_rdy_i;
      new_s.src2.val = disp_src2_val_i;
    end
  end

  rs_age_matrix #(
    .RS_ENTRY (RS_ENTRY)
  ) u_age (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .alloc_i   (alloc_fire_s),
    .dealloc_i (grant_s),
    .req_i     (req_s),
    .grant_o   (grant_s)
  );

  // Granted entry payload (grant is one-hot, so AND-OR is a clean mux).
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < RS_ENTRY; i++) begin
      sel_s = rs_entry_t'(sel_s | (woken_s[i] & {RS_ENTRY_WIDTH{grant_s[i]}}));
    end
  end

  // Next entry state: dispatch write, issue clear, flush squash.
  always_comb begin
    for (int i = 0; i < RS_ENTRY; i++) begin
      if (alloc_fire_s[i]) begin
        ent_d[i] = new_s;
      end else begin
        ent_d[i]       = woken_s[i];
        ent_d[i].valid = woken_s[i].valid & ~grant_s[i];
      end
      ent_d[i].valid = ent_d[i].valid & ~flush_i;
    end
  end

  // Ready for dispatch next cycle iff some slot will be free.
  always_comb begin
    disp_ready_d = 1'b0;
    for (int i = 0; i < RS_ENTRY; i++) begin
      disp_ready_d = disp_ready_d | ~ent_d[i].valid;
    end
  end

  assign exe_v_d = (|grant_s) & ~flush_i;

  // Station entry storage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < RS_ENTRY; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_ENTRY; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // Registered issue outputs and dispatch-ready flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      disp_ready_q <= 1'b1;
      exe_v_q      <= 1'b0;
      opcode_q     <= '0;
      operand1_q   <= '0;
      operand2_q   <= '0;
      rob_dest_q   <= '0;
      reg_dest_q   <= '0;
    end else begin
      disp_ready_q <= disp_ready_d;
      exe_v_q      <= exe_v_d;
      if (exe_v_d) begin
        opcode_q   <= sel_s.opcode;
        operand1_q <= sel_s.src1.val;
        operand2_q <= sel_s.src2.val;
        rob_dest_q <= sel_s.rob_dest;
        reg_dest_q <= sel_s.reg_dest;
      end else begin
        opcode_q   <= opcode_q;
        operand1_q <= operand1_q;
        operand2_q <= operand2_q;
        rob_dest_q <= rob_dest_q;
        reg_dest_q <= reg_dest_q;
      end
    end
  end

  assign disp_ready_o = disp_ready_q;
  assign exe_v_o      = exe_v_q;
  assign opcode_o     = opcode_q;
  assign operand1_o   = operand1_q;
  assign operand2_o   = operand2_q;
  assign rob_dest_o   = rob_dest_q;
  assign reg_dest_o   = reg_dest_q;

endmodule

// File: tb/tb_rs_logic.sv
// tb_rs_logic
// Directed + random bench for rs_logic. A queue-based reference model
// (queue order = dispatch order, so the oldest ready op is the first ready
// element) predicts disp_ready_o every cycle and the issue outputs after
// every clock edge.
module tb_rs_logic;
  import rs_logic_pkg::*;

  localparam int RS_ENTRY = 4;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk_i = 1'b0;
  logic                   reset_i, flush_i, disp_v_i, disp_ready_o;
  logic [WIDTH_OP-1:0]    disp_opcode_i;
  logic                   disp_src1_rdy_i, disp_src2_rdy_i;
  logic [TAG_W-1:0]       disp_src1_tag_i, disp_src2_tag_i;
  logic [WORD_SIZE_P-1:0] disp_src1_val_i, disp_src2_val_i;
  logic [ROB_W-1:0]       disp_rob_dest_i;
  logic [TAG_W-1:0]       disp_reg_dest_i;
  cdb_t                   cdb_s;
  logic [CDB_WIDTH-1:0]   cdb_i;
  logic                   exe_v_o;
  logic [WIDTH_OP-1:0]    opcode_o;
  logic [WORD_SIZE_P-1:0] operand1_o, operand2_o;
  logic [ROB_W-1:0]       rob_dest_o;
  logic [TAG_W-1:0]       reg_dest_o;

  assign cdb_i = cdb_s;

  rs_logic #(.RS_ENTRY(RS_ENTRY)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .disp_v_i(disp_v_i), .disp_ready_o(disp_ready_o), .disp_opcode_i(disp_opcode_i),
    .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src2_rdy_i(disp_src2_rdy_i),
    .disp_src1_tag_i(disp_src1_tag_i), .disp_src2_tag_i(disp_src2_tag_i),
    .disp_src1_val_i(disp_src1_val_i), .disp_src2_val_i(disp_src2_val_i),
    .disp_rob_dest_i(disp_rob_dest_i), .disp_reg_dest_i(disp_reg_dest_i),
    .cdb_i(cdb_i), .exe_v_o(exe_v_o), .opcode_o(opcode_o),
    .operand1_o(operand1_o), .operand2_o(operand2_o),
    .rob_dest_o(rob_dest_o), .reg_dest_o(reg_dest_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  op;
    logic        r1, r2;
    logic [4:0]  t1, t2;
    logic [15:0] v1, v2;
    logic [3:0]  rob;
    logic [4:0]  rd;
  } mop_t;

  mop_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_v_i = 1'b0; flush_i = 1'b0; cdb_s = '0;
  endtask

  task automatic disp(input logic [2:0] op, input logic r1, input logic [4:0] t1,
                      input logic [15:0] v1, input logic r2, input logic [4:0] t2,
                      input logic [15:0] v2, input logic [3:0] rob, input logic [4:0] rd);
    disp_v_i = 1'b1; disp_opcode_i = op;
    disp_src1_rdy_i = r1; disp_src1_tag_i = t1; disp_src1_val_i = v1;
    disp_src2_rdy_i = r2; disp_src2_tag_i = t2; disp_src2_val_i = v2;
    disp_rob_dest_i = rob; disp_reg_dest_i = rd;
  endtask

  task automatic bcast(input logic [4:0] dest, input logic [15:0] res);
    cdb_s = '0; cdb_s.valid = 1'b1; cdb_s.dest = dest; cdb_s.result = res;
  endtask

  // One clock: predict from the current inputs, advance, compare.
  task automatic tick();
    mop_t e, iss;
    bit   fire, ev, h1, h2, el;
    int   sel;
    chk("disp_ready", {31'd0, disp_ready_o}, {31'd0, q.size() < RS_ENTRY});
    fire = disp_v_i && (q.size() < RS_ENTRY);
    ev = 1'b0; sel = -1;
    if (flush_i) begin
      q.delete();
    end else begin
      for (int k = 0; k < q.size(); k++) begin
        h1 = cdb_s.valid && !q[k].r1 && (q[k].t1 == cdb_s.dest);
        h2 = cdb_s.valid && !q[k].r2 && (q[k].t2 == cdb_s.dest);
        el = BYP ? ((q[k].r1 || h1) && (q[k].r2 || h2)) : (q[k].r1 && q[k].r2);
        if (el && sel < 0) sel = k;
      end
      if (sel >= 0) begin
        ev = 1'b1; iss = q[sel];
        if (!iss.r1) iss.v1 = cdb_s.result;
        if (!iss.r2) iss.v2 = cdb_s.result;
        q.delete(sel);
      end
      for (int k = 0; k < q.size(); k++) begin
        if (cdb_s.valid && !q[k].r1 && q[k].t1 == cdb_s.dest) begin q[k].r1 = 1'b1; q[k].v1 = cdb_s.result; end
        if (cdb_s.valid && !q[k].r2 && q[k].t2 == cdb_s.dest) begin q[k].r2 = 1'b1; q[k].v2 = cdb_s.result; end
      end
      if (fire) begin
        e.op = disp_opcode_i; e.rob = disp_rob_dest_i; e.rd = disp_reg_dest_i;
        e.r1 = disp_src1_rdy_i; e.t1 = disp_src1_tag_i; e.v1 = disp_src1_val_i;
        e.r2 = disp_src2_rdy_i; e.t2 = disp_src2_tag_i; e.v2 = disp_src2_val_i;
        if (cdb_s.valid && !e.r1 && e.t1 == cdb_s.dest) begin e.r1 = 1'b1; e.v1 = cdb_s.result; end
        if (cdb_s.valid && !e.r2 && e.t2 == cdb_s.dest) begin e.r2 = 1'b1; e.v2 = cdb_s.result; end
        q.push_back(e);
      end
    end
    @(posedge clk_i); #1;
    chk("exe_v", {31'd0, exe_v_o}, {31'd0, ev});
    if (ev) begin
      chk("opcode", {29'd0, opcode_o}, {29'd0, iss.op});
      chk("operand1", {16'd0, operand1_o}, {16'd0, iss.v1});
      chk("operand2", {16'd0, operand2_o}, {16'd0, iss.v2});
      chk("rob_dest", {28'd0, rob_dest_o}, {28'd0, iss.rob});
      chk("reg_dest", {27'd0, reg_dest_o}, {27'd0, iss.rd});
    end
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    disp(3'd0, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 4'd0, 5'd0);
    disp_v_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk("rst_exe_v", {31'd0, exe_v_o}, 32'd0);
    chk("rst_opcode", {29'd0, opcode_o}, 32'd0);
    chk("rst_op1", {16'd0, operand1_o}, 32'd0);
    chk("rst_op2", {16'd0, operand2_o}, 32'd0);
    chk("rst_rob", {28'd0, rob_dest_o}, 32'd0);
    chk("rst_reg", {27'd0, reg_dest_o}, 32'd0);
    chk("rst_ready", {31'd0, disp_ready_o}, 32'd1);

    // AND with both sources ready: issues two cycles after dispatch.
    disp(OP_AND, 1'b1, 5'd1, 16'h00F0, 1'b1, 5'd2, 16'h0FF0, 4'd3, 5'd9);
    tick(); idle(); tick();
    chk("and_exe_v", {31'd0, exe_v_o}, 32'd1);
    chk("and_op1", {16'd0, operand1_o}, 32'h00F0);
    chk("and_op2", {16'd0, operand2_o}, 32'h0FF0);
    tick();

    // XOR waiting on tag 5, CDB two cycles later.
    disp(OP_XOR, 1'b0, 5'd5, 16'hDEAD, 1'b1, 5'd6, 16'h00FF, 4'd4, 5'd10);
    tick(); idle(); tick();
    bcast(5'd5, 16'h1234); tick(); idle();
    chk("xor_wake_t1", {31'd0, exe_v_o}, {31'd0, BYP});
    tick();
    chk("xor_wake_t2", {31'd0, exe_v_o}, {31'd0, !BYP});
    tick(); tick();

    // OR waiting on tag 7 while the CDB broadcasts tag 7.
    disp(OP_OR, 1'b0, 5'd7, 16'h0000, 1'b1, 5'd8, 16'h5555, 4'd5, 5'd11);
    bcast(5'd7, 16'hA5A5); tick(); idle(); tick();
    chk("or_capture_exe", {31'd0, exe_v_o}, 32'd1);
    chk("or_capture_op1", {16'd0, operand1_o}, 32'hA5A5);
    tick();

    // Fill the station, attempt an extra dispatch, wake everything at once.
    for (int k = 0; k < RS_ENTRY; k++) begin
      disp(OP_LSLS, 1'b0, 5'd10, 16'h0, 1'b1, 5'd0, 16'(k), 4'(k + 6), 5'(k + 12));
      tick();
    end
    chk("full_ready", {31'd0, disp_ready_o}, 32'd0);
    disp(OP_RORS, 1'b1, 5'd0, 16'h1111, 1'b1, 5'd0, 16'h2222, 4'd15, 5'd31);
    tick(); idle();
    bcast(5'd10, 16'hBEEF); tick(); idle();
    repeat (RS_ENTRY + 2) tick();

    // A (older, higher slot) and B (younger, lower slot) woken together.
    disp(OP_NEG, 1'b1, 5'd0, 16'h0001, 1'b1, 5'd0, 16'h0, 4'd1, 5'd1); tick();
    disp(OP_ASRS, 1'b0, 5'd3, 16'h0, 1'b1, 5'd0, 16'hAAAA, 4'd2, 5'd2); tick();
    disp(OP_LSRS, 1'b0, 5'd3, 16'h0, 1'b1, 5'd0, 16'hBBBB, 4'd3, 5'd3); tick(); idle();
    bcast(5'd3, 16'h7777); tick(); idle();
    repeat (4) tick();

    // Flush with three waiting entries and a simultaneous dispatch.
    for (int k = 0; k < 3; k++) begin
      disp(OP_XOR, 1'b0, 5'd20, 16'h0, 1'b1, 5'd0, 16'h0, 4'(k), 5'(k)); tick();
    end
    disp(OP_AND, 1'b1, 5'd0, 16'hCAFE, 1'b1, 5'd0, 16'hF00D, 4'd9, 5'd9);
    flush_i = 1'b1; tick(); idle();
    chk("flush_ready", {31'd0, disp_ready_o}, 32'd1);
    chk("flush_exe_v", {31'd0, exe_v_o}, 32'd0);
    bcast(5'd20, 16'h4321); tick(); idle();
    repeat (3) tick();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      disp(3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           16'($urandom), ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
           16'($urandom), 4'($urandom), 5'($urandom));
      disp_v_i = ($urandom_range(0, 1) == 1);
      cdb_s = '0;
      if ($urandom_range(0, 2) == 0) bcast(5'($urandom_range(0, 7)), 16'($urandom));
      flush_i = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_logic.md
# rs_logic

Reservation station for the logic functional unit. It buffers dispatched logic ops (AND/XOR/OR/NEG/LSLS/LSRS/ASRS/RORS) until both source operands are available, snoops the CDB to wake waiting operands, and issues the oldest ready op, one per cycle, into the logic FU's execute inputs. It sits between the dispatch stage and the logic FU, driving the FU's `exe_v_i`, `opcode_i`, `operand1_i`, `operand2_i`, `rob_dest_i` and `reg_dest_i`.

## Interface

Parameters:
- `RS_ENTRY`, default 4: number of station entries; must be ≥2.

Ports:
- `clk_i` input, 1 bit: clock.
- `reset_i` input, 1 bit: synchronous, active-high reset.
- `flush_i` input, 1 bit: synchronous squash of all entries.
- `disp_v_i` input, 1 bit: dispatch valid.
- `disp_ready_o` output, 1 bit: station can accept a dispatch.
- `disp_opcode_i` input, `WIDTH_OP` bits: op to buffer.
- `disp_src1_rdy_i`, `disp_src2_rdy_i` input, 1 bit each: operand value is valid.
- `disp_src1_tag_i`, `disp_src2_tag_i` input, `$clog2(NUM_PHYS_REG)` bits each: producer physical register.
- `disp_src1_val_i`, `disp_src2_val_i` input, `WORD_SIZE_P` bits each: operand value.
- `disp_rob_dest_i` input, `$clog2(ROB_ENTRY)` bits: ROB slot.
- `disp_reg_dest_i` input, `$clog2(NUM_PHYS_REG)` bits: destination physical register.
- `cdb_i` input, `CDB_WIDTH` bits: broadcast result, cast to `cdb_t` (valid, dest, flags, result).
- `exe_v_o` input-side strobe to the FU, output, 1 bit: issue valid.
- `opcode_o` output, `WIDTH_OP` bits.
- `operand1_o`, `operand2_o` output, `WORD_SIZE_P` bits each.
- `rob_dest_o` output, `$clog2(ROB_ENTRY)` bits.
- `reg_dest_o` output, `$clog2(NUM_PHYS_REG)` bits.

## Operation

- Entry state: valid, opcode, per-source {rdy, tag, val}, rob_dest, reg_dest.
- Dispatch is accepted when `disp_v_i && disp_ready_o`. It is written into the lowest-index free entry.
- `disp_ready_o` is 1 iff at least one entry is free at the start of the cycle. An entry issuing in the same cycle does not free space for that cycle's dispatch.
- Unary ops (NEG) arrive with `disp_src2_rdy_i=1`; the station does not decode the opcode.
- CDB wake-up: when `cdb.valid` is set, every valid entry source with rdy=0 and tag==`cdb.dest` captures `cdb.result` and sets rdy.
- Dispatch-cycle capture: a dispatching source with rdy=0 whose tag matches a valid CDB in the same cycle is stored already ready, with the CDB value. This capture is unconditional.
- Select: among entries with valid && src1.rdy && src2.rdy, the oldest by dispatch order is chosen. Age is tracked by an age matrix, so ordering is exact regardless of entry index.
- Issue: the selected entry's fields are registered onto the outputs, and the entry's valid is cleared. At most one issue per cycle.
- Flush: clears every entry valid and the age state. `exe_v_o` is 0 on the next cycle. A dispatch in the flush cycle is dropped. Flush has priority over dispatch, wake-up and issue.
- Reset: same effect as flush. All outputs reset to 0, except `disp_ready_o`, which is 1 after reset.

## Timing

- Issue outputs are registered.
- Dispatch at cycle t with both sources ready: entry valid at t+1, `exe_v_o`=1 at t+2 if it is the oldest ready entry.
- CDB match at cycle t on a waiting entry: rdy set at t+1, `exe_v_o` at t+2 (t+1 with the bypass enabled, see Configuration).
- `exe_v_o` is a single-cycle pulse per issued op. The FU always accepts, so there is no stall input.
- Ages stay consistent when a simultaneous dispatch and issue hit different entries. The new entry is youngest.

## Configuration

- `RS_WAKEUP_BYPASS_EN` defined:
  - An entry whose last missing operand matches the CDB in cycle t is eligible for select in cycle t.
  - The CDB result is muxed into the operand path, so `exe_v_o` rises at t+1.
  - A dispatching entry is never same-cycle eligible.
- Undefined: eligibility uses only registered rdy bits, and wake-to-issue is 2 cycles.

## Structure

- Shared package holds `WIDTH_OP`, `WORD_SIZE_P`, `ROB_ENTRY`, `NUM_PHYS_REG`, `cdb_t`, `CDB_WIDTH`, and a new `rs_entry_t` packed struct with a `RS_ENTRY_WIDTH` constant.
- Sub-module `rs_age_matrix` (parameter `RS_ENTRY`):
  - Inputs: alloc one-hot, dealloc one-hot, request vector, flush.
  - Output: oldest-request one-hot grant.
  - Row i bit j=1 means entry i is older than entry j.

## Test plan

- Reset, then dispatch AND with src1=0x00F0 ready, src2=0x0FF0 ready → `exe_v_o`=1 two cycles later with operand1=0x00F0, operand2=0x0FF0, rob_dest/reg_dest echoed.
- Dispatch XOR with src1 waiting on tag 5. CDB {valid, dest=5, result=0x1234} two cycles later → operand1_o=0x1234. `exe_v_o` rises 2 cycles after the CDB without the macro, 1 cycle after with it.
- Dispatch OR waiting on tag 7 while the CDB broadcasts dest=7 in the same cycle → entry stored ready, issues at t+2.
- Fill all `RS_ENTRY` entries with non-ready ops → `disp_ready_o`=0. Wake all four in one CDB → issues occur in dispatch order, one per cycle, and `disp_ready_o` returns to 1 after the first issue.
- Entries A (older), B both become ready in the same cycle → A issues first, then B.
- Three valid entries, assert `flush_i` with a simultaneous dispatch → no `exe_v_o` afterwards, `disp_ready_o`=1, and the dropped dispatch never issues.
